// File: rtl/whack_judge.sv
// whack_judge: whack-a-mole round sequencer and hit judge.
// Lights one mole per round from an LFSR pick, judges debounced key pulses
// as hit/miss, keeps a saturating two-digit BCD score and counts rounds.
// Optional build macro WHACK_MISS_PENALTY_EN: each miss also subtracts one
// point from the BCD score, floored at 00.
module whack_judge #(
  parameter int unsigned N        = 8,
  parameter int unsigned SHOW_CYC = 50000000,
  parameter int unsigned GAP_CYC  = 12500000,
  parameter int unsigned ROUNDS   = 20,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] key_pulse,
  output logic [N-1:0] mole,
  output logic         hit,
  output logic         miss,
  output logic [7:0]   score_bcd,
  output logic [7:0]   rounds_left,
  output logic         game_over
);

  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned TMAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int unsigned TW   = $clog2(TMAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [N-1:0]    mole_q, mole_d;
  logic            hit_q, hit_d;
  logic            miss_q, miss_d;
  logic [7:0]      score_q, score_d;
  logic [7:0]      rounds_q, rounds_d;
  logic            over_q, over_d;

  logic [IW-1:0]   idx_raw;
  logic [IW-1:0]   idx_pick;
  logic [7:0]      hit_score;
  logic [7:0]      miss_score;
  logic            key_hit;
  logic            key_any;
  logic            show_end;
  logic            gap_end;

  // BCD +1 with saturation at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v != 8'h99) begin
      if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

`ifdef WHACK_MISS_PENALTY_EN
  // BCD -1 with floor at 00
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v != 8'h00) begin
      if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
      else                r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Miss costs one point
  assign miss_score = bcd_dec(score_q);
`else
  // Miss leaves the score alone
  assign miss_score = score_q;
`endif

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free running
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // New hole index; bumped by one (wrapping) if it would repeat the last hole
  assign idx_raw  = lfsr_q[IW-1:0];
  assign idx_pick = (idx_raw == idx_q) ? idx_raw + IW'(1) : idx_raw;

  assign hit_score = bcd_inc(score_q);
  assign key_hit   = key_pulse[idx_q];
  assign key_any   = |key_pulse;
  assign show_end  = (timer_q == TW'(SHOW_CYC - 1));
  assign gap_end   = (timer_q == TW'(GAP_CYC - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    score_d  = score_q;
    rounds_d = rounds_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          score_d  = 8'h00;
          rounds_d = 8'(ROUNDS);
          idx_d    = idx_pick;
          timer_d  = '0;
          state_d  = ST_SHOW;
        end
      end

      ST_SHOW: begin
        timer_d = timer_q + TW'(1);
        if (key_hit) begin
          hit_d   = 1'b1;
          score_d = hit_score;
          timer_d = '0;
          state_d = ST_GAP;
        end else if (key_any || show_end) begin
          miss_d  = 1'b1;
          score_d = miss_score;
          timer_d = '0;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        timer_d = timer_q + TW'(1);
        if (gap_end) begin
          rounds_d = rounds_q - 8'd1;
          timer_d  = '0;
          if (rounds_q == 8'd1) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_pick;
            state_d = ST_SHOW;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    mole_d = (state_d == ST_SHOW) ? (N'(1) << idx_d) : '0;
    over_d = (state_d == ST_DONE);
  end

  // State and output registers; index register starts at hole 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED;
      idx_q    <= '0;
      timer_q  <= '0;
      mole_q   <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      score_q  <= 8'h00;
      rounds_q <= 8'd0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      mole_q   <= mole_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      score_q  <= score_d;
      rounds_q <= rounds_d;
      over_q   <= over_d;
    end
  end

  assign mole        = mole_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign score_bcd   = score_q;
  assign rounds_left = rounds_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_whack_judge.sv
// tb_whack_judge: directed bench for whack_judge.
// dut1 plays 3-round games, dut2 a 120-round game for BCD carry/saturation.
module tb_whack_judge;

  localparam int unsigned N    = 8;
  localparam int unsigned SHOW = 10;
  localparam int unsigned GAP  = 4;
  localparam int unsigned R1   = 3;
  localparam int unsigned R2   = 120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_drv;
  logic [N-1:0] key_drv;
  bit           sel;

  logic         start1, start2;
  logic [N-1:0] key1, key2;
  logic [N-1:0] mole1, mole2;
  logic         hit1, hit2, miss1, miss2, over1, over2;
  logic [7:0]   score1, score2, rounds1, rounds2;

  logic [N-1:0] mole_s;
  logic         hit_s, miss_s, over_s;
  logic [7:0]   score_s, rounds_s;

  assign start1   = sel ? 1'b0 : start_drv;
  assign start2   = sel ? start_drv : 1'b0;
  assign key1     = sel ? '0 : key_drv;
  assign key2     = sel ? key_drv : '0;
  assign mole_s   = sel ? mole2 : mole1;
  assign hit_s    = sel ? hit2 : hit1;
  assign miss_s   = sel ? miss2 : miss1;
  assign over_s   = sel ? over2 : over1;
  assign score_s  = sel ? score2 : score1;
  assign rounds_s = sel ? rounds2 : rounds1;

  whack_judge #(.N(N), .SHOW_CYC(SHOW), .GAP_CYC(GAP), .ROUNDS(R1), .SEED(16'hACE1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_pulse(key1), .mole(mole1),
    .hit(hit1), .miss(miss1), .score_bcd(score1), .rounds_left(rounds1), .game_over(over1)
  );

  whack_judge #(.N(N), .SHOW_CYC(SHOW), .GAP_CYC(GAP), .ROUNDS(R2), .SEED(16'hACE1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .key_pulse(key2), .mole(mole2),
    .hit(hit2), .miss(miss2), .score_bcd(score2), .rounds_left(rounds2), .game_over(over2)
  );

  // Reference LFSR; m_used is the value the DUT sampled at the last edge
  logic [15:0] m_lfsr, m_used;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 16'hACE1;
      m_used <= 16'hACE1;
    end else begin
      m_used <= m_lfsr;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  int           n_checks = 0;
  int           n_errors = 0;
  int           last_idx [2];
  int           pts      [2];
  int           rounds_exp [2];
  logic [N-1:0] prev_mole [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd_of(input int p);
    return 8'((p / 10) * 16 + (p % 10));
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      last_idx[i]   = 0;
      pts[i]        = 0;
      rounds_exp[i] = 0;
      prev_mole[i]  = '0;
    end
  endtask

  // Pulse start at a negedge; returns at the first SHOW cycle
  task automatic do_start();
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    pts[sel]        = 0;
    rounds_exp[sel] = sel ? int'(R2) : int'(R1);
    chk("start_rounds", 32'(rounds_s), 32'(rounds_exp[sel]));
    chk("start_score", 32'(score_s), 32'h00);
    chk("start_over", 32'(over_s), 32'd0);
  endtask

  // One round: press_at = SHOW cycle of the press (0 = none), wrong = wrong key,
  // start_at = SHOW cycle with a stray start pulse (also repeated in GAP)
  task automatic play_round(input int press_at, input bit wrong, input int start_at);
    int           raw, e, ncyc;
    logic [N-1:0] oh;
    bit           exp_hit;
    raw = int'(m_used) % int'(N);
    e   = (raw == last_idx[sel]) ? (raw + 1) % int'(N) : raw;
    last_idx[sel] = e;
    oh = N'(1) << e;
    if (prev_mole[sel] != '0)
      chk("norepeat", 32'(mole_s != prev_mole[sel]), 32'd1);
    prev_mole[sel] = mole_s;
    ncyc = (press_at == 0) ? int'(SHOW) : press_at;
    for (int c = 1; c <= ncyc; c++) begin
      chk("mole", 32'(mole_s), 32'(oh));
      chk("show_quiet", 32'({hit_s, miss_s}), 32'd0);
      if (c == press_at) key_drv = wrong ? N'(1) << ((e + 3) % int'(N)) : oh;
      if (c == start_at) start_drv = 1'b1;
      @(negedge clk);
      key_drv   = '0;
      start_drv = 1'b0;
    end
    exp_hit = (press_at != 0) && !wrong;
    if (exp_hit) begin
      pts[sel] = (pts[sel] >= 99) ? 99 : pts[sel] + 1;
    end else begin
`ifdef WHACK_MISS_PENALTY_EN
      pts[sel] = (pts[sel] == 0) ? 0 : pts[sel] - 1;
`endif
    end
    chk("hit", 32'(hit_s), 32'(exp_hit));
    chk("miss", 32'(miss_s), 32'(!exp_hit));
    chk("score", 32'(score_s), 32'(bcd_of(pts[sel])));
    chk("gap_mole", 32'(mole_s), 32'd0);
    for (int g = 1; g <= int'(GAP); g++) begin
      if (g > 1) chk("gap_quiet", 32'({hit_s, miss_s, |mole_s}), 32'd0);
      chk("gap_rounds", 32'(rounds_s), 32'(rounds_exp[sel]));
      if (g == 2) begin
        key_drv = '1;
        if (start_at != 0) start_drv = 1'b1;
      end
      @(negedge clk);
      key_drv   = '0;
      start_drv = 1'b0;
    end
    rounds_exp[sel]--;
    chk("rounds", 32'(rounds_s), 32'(rounds_exp[sel]));
    chk("over", 32'(over_s), 32'(rounds_exp[sel] == 0));
    if (rounds_exp[sel] == 0) chk("done_mole", 32'(mole_s), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start_drv = 1'b0;
    key_drv   = '0;
    sel       = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_mole", 32'(mole1), 32'd0);
    chk("rst_pulses", 32'({hit1, miss1}), 32'd0);
    chk("rst_score", 32'(score1), 32'd0);
    chk("rst_rounds", 32'(rounds1), 32'd0);
    chk("rst_over", 32'(over1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mole", 32'(mole1), 32'd0);

    // Game A: no presses; stray start pulses in round 2 must be ignored
    do_start();
    play_round(0, 1'b0, 0);
    play_round(0, 1'b0, 4);
    play_round(0, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk("a_over_hold", 32'(over1), 32'd1);
    chk("a_score", 32'(score1), 32'h00);

    // Game B from DONE: correct key on SHOW cycle 3 every round
    do_start();
    for (int r = 0; r < int'(R1); r++) play_round(3, 1'b0, 0);
    chk("b_score", 32'(score1), 32'h03);

    // Game C: wrong key at 00, hit on the timeout cycle, wrong key at 01
    do_start();
    play_round(2, 1'b1, 0);
    play_round(int'(SHOW), 1'b0, 0);
    play_round(5, 1'b1, 0);
`ifdef WHACK_MISS_PENALTY_EN
    chk("c_score", 32'(score1), 32'h00);
`else
    chk("c_score", 32'(score1), 32'h01);
`endif

    // Asynchronous reset in the middle of a SHOW window
    do_start();
    play_round(2, 1'b0, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_mole", 32'(mole1), 32'd0);
    chk("arst_score", 32'(score1), 32'd0);
    chk("arst_rounds", 32'(rounds1), 32'd0);
    chk("arst_pulses", 32'({hit1, miss1, over1}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({hit1, miss1, over1, |mole1}), 32'd0);
    end

    // Game D on the 120-round instance: all hits except a wrong key at score 10
    sel = 1'b1;
    @(negedge clk);
    do_start();
    for (int r = 1; r <= int'(R2); r++) begin
      if (r == 11) begin
        play_round(1, 1'b1, 0);
`ifdef WHACK_MISS_PENALTY_EN
        chk("d_pen_09", 32'(score2), 32'h09);
`else
        chk("d_nopen_10", 32'(score2), 32'h10);
`endif
      end else begin
        play_round(1, 1'b0, 0);
      end
      if (r == 9)  chk("d_score_09", 32'(score2), 32'h09);
      if (r == 10) chk("d_score_10", 32'(score2), 32'h10);
    end
    chk("d_score_99", 32'(score2), 32'h99);
    chk("d_over", 32'(over2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
